dpram_porta_ctrl: RTL

Command front-end that sits directly upstream of the DPRAM's port A and drives its pins: addr_A, datain_A, wr_enA and the active-low enA. It buffers read/write commands from a valid/ready producer in a small in-order FIFO and issues at most one command per cycle to the RAM. It captures dataout_A after the RAM read latency and returns it as a one-cycle response pulse. After reset it can optionally sweep-clear the whole RAM.

---
 rtl/dpram_pkg.sv | 19 +
 rtl/dpram_cmd_fifo.sv | 56 +++++
 rtl/dpram_porta_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared types for the DPRAM port-A command front-end.
// Default widths match the DPRAM this block drives.
package dpram_pkg;

  localparam int DPRAM_ADDR_WIDTH = 5;
  localparam int DPRAM_DATA_WIDTH = 8;

  typedef struct packed {
    logic                        wr;
    logic [DPRAM_ADDR_WIDTH-1:0] addr;
    logic [DPRAM_DATA_WIDTH-1:0] data;
  } dpram_cmd_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/dpram_cmd_fifo.sv
// In-order command FIFO; no pass-through, so a full FIFO
// refuses a push even when it pops in the same cycle.
module dpram_cmd_fifo
  import dpram_pkg::*;
#(
  parameter type T          = dpram_cmd_t,
  parameter int  DEPTH      = 4,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/dpram_porta_ctrl.sv
// DPRAM port-A front-end: queues commands, issues one per
// cycle, returns read data in order, optional clear sweep.
module dpram_porta_ctrl
  import dpram_pkg::*;
#(
  parameter int  ADDR_WIDTH     = DPRAM_ADDR_WIDTH,
  parameter int  DATA_WIDTH     = DPRAM_DATA_WIDTH,
  parameter int  FIFO_DEPTH     = 4,
  parameter int  RD_LAT         = 1,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_A,
  input  logic                  rst_A,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  issue_hold,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [CW-1:0]         fifo_count,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic [DATA_WIDTH-1:0] datain_A,
  output logic                  wr_enA,
  output logic                  enA,
  input  logic [DATA_WIDTH-1:0] dataout_A
);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  localparam ctrl_state_e RST_ST =
    (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  ctrl_state_e           r_state;
  ctrl_state_e           w_nxt_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_nxt_clr;
  logic [RD_LAT:0]       r_tag;
  cmd_t                  w_cmd;
  cmd_t                  w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic                  w_en_n;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;

  assign w_cmd     = '{wr: cmd_wr, addr: cmd_addr, data: cmd_wdata};
  assign cmd_ready = rst_A && (r_state == RUN) && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign busy      = (r_state == CLEAR);

  dpram_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_A),
    .rst_n (rst_A),
    .push  (w_push),
    .din   (w_cmd),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      r_state   <= RST_ST;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_clr_cnt <= w_nxt_clr;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_clr   = r_clr_cnt;
    w_en_n      = 1'b1;
    w_wr        = 1'b0;
    w_addr      = addr_A;
    w_din       = datain_A;
    w_pop       = 1'b0;
    w_rd_issue  = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_en_n    = 1'b0;
        w_wr      = 1'b1;
        w_addr    = r_clr_cnt;
        w_din     = '0;
        w_nxt_clr = r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == '1) w_nxt_state = RUN;
      end
      RUN: begin
        if (!w_empty && !issue_hold) begin
          w_pop      = 1'b1;
          w_en_n     = 1'b0;
          w_wr       = w_head.wr;
          w_addr     = w_head.addr;
          w_din      = w_head.data;
          w_rd_issue = !w_head.wr;
        end
      end
      default: ;
    endcase
  end

  // r_tag[k] marks a read issued k+1 cycles ago
  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      enA       <= 1'b1;
      wr_enA    <= 1'b0;
      addr_A    <= '0;
      datain_A  <= '0;
      r_tag     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      enA       <= w_en_n;
      wr_enA    <= w_wr;
      addr_A    <= w_addr;
      datain_A  <= w_din;
      r_tag     <= (r_tag << 1) | (RD_LAT + 1)'(w_rd_issue);
      rsp_valid <= r_tag[RD_LAT];
      if (r_tag[RD_LAT]) rsp_rdata <= dataout_A;
    end
  end

endmodule
